// File: rtl/power_root_pkg.sv
// Shared types and constants for power_root_sum.
// Root-cycle helper used to size the root phase.
package power_root_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQ,
    S_ROOT,
    S_SUM,
    S_DONE
  } state_t;

  localparam logic MODE_CBRT = 1'b0;
  localparam logic MODE_SQRT = 1'b1;

  function automatic int root_cycles(
    input int   w,
    input logic m
  );
    return (m == MODE_SQRT) ? (w / 2)
                            : ((w + 2) / 3);
  endfunction

endpackage

// File: rtl/power_root_sum_mult.sv
// Shift-add multiplier, one partial product
// per cycle, W cycles per product.
module seq_mult #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           ready_o,
  output logic [2*W-1:0] p_o
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mc_q;
  logic [W-1:0]   mp_q;
  logic [2*W-1:0] p_q;
  logic [CW-1:0]  cnt_q;

  // load operands, then add one shifted partial product per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_q  <= '0;
      mp_q  <= '0;
      p_q   <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      mc_q  <= (2*W)'(a_i);
      mp_q  <= b_i;
      p_q   <= '0;
      cnt_q <= CW'(W);
    end else if (cnt_q != '0) begin
      if (mp_q[0]) begin
        p_q <= p_q + mc_q;
      end
      mc_q  <= mc_q << 1;
      mp_q  <= mp_q >> 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // high during the last step; product is final after this edge
  assign ready_o = (cnt_q == CW'(1));
  assign p_o     = p_q;

endmodule

// File: rtl/power_root_sum.sv
// y = a^2 + floor(root(b)), cube or square root
// by restoring digit recurrence, fixed latency.
module power_root_sum
  import power_root_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ready,
  output logic         busy,
  output logic         ovf
);

  localparam int RC = root_cycles(W, MODE_CBRT);
  localparam int RS = root_cycles(W, MODE_SQRT);
  localparam int RW = W + 4;
  localparam int BW = 3 * RC;
  localparam int CW = $clog2(RS + 1);
  localparam int SW = 2 * W + 1;

  state_t state_q, state_d;

  logic          mode_q;
  logic [BW-1:0] bsh_q, bsh_d;
  logic [RW-1:0] rem_q, rem_d;
  logic [RW-1:0] root_q, root_d;
  logic [RW-1:0] sq_q, sq_d;
  logic [CW-1:0] rcnt_q;
  logic [SW-1:0] sum_q;
  logic [W-1:0]  y_q;
  logic          ovf_q;
  logic          ready_q;

  logic [RW-1:0] rem_n, trial, y2, ysq, h;
  logic          ge;
  logic          accept;
  logic          mult_rdy;
  logic [2*W-1:0] prod;

  assign accept = (state_q == S_IDLE) && start;

  seq_mult #(.W(W)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start_i (accept),
    .a_i     (a),
    .b_i     (a),
    .ready_o (mult_rdy),
    .p_o     (prod)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SQ;
      S_SQ:   if (mult_rdy) state_d = S_ROOT;
      S_ROOT: if (rcnt_q == CW'(1)) state_d = S_SUM;
      S_SUM:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // one root digit; cube keeps root^2 to avoid a multiplier
  always_comb begin
    rem_n  = '0;
    trial  = '0;
    y2     = root_q << 1;
    ysq    = sq_q << 2;
    h      = '0;
    ge     = 1'b0;
    rem_d  = rem_q;
    root_d = root_q;
    sq_d   = sq_q;
    bsh_d  = bsh_q;
    if (mode_q == MODE_SQRT) begin
      rem_n  = (rem_q << 2)
             | RW'(bsh_q[BW-1 -: 2]);
      trial  = (root_q << 2) | RW'(1);
      ge     = (rem_n >= trial);
      rem_d  = ge ? rem_n - trial : rem_n;
      root_d = y2 | RW'(ge);
      bsh_d  = bsh_q << 2;
    end else begin
      rem_n  = (rem_q << 3)
             | RW'(bsh_q[BW-1 -: 3]);
      h      = ysq + y2;
      trial  = (h << 1) + h + RW'(1);
      ge     = (rem_n >= trial);
      rem_d  = ge ? rem_n - trial : rem_n;
      root_d = y2 | RW'(ge);
      sq_d   = ge ? ysq + (y2 << 1) + RW'(1)
                  : ysq;
      bsh_d  = bsh_q << 3;
    end
  end

  // operand latch, root iteration, final sum and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_CBRT;
      bsh_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      sq_q    <= '0;
      rcnt_q  <= '0;
      sum_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            bsh_q  <= (mode == MODE_SQRT)
                    ? (BW'(b) << (BW - W))
                    : BW'(b);
            rem_q  <= '0;
            root_q <= '0;
            sq_q   <= '0;
          end
        end
        S_SQ: begin
          if (mult_rdy) begin
            rcnt_q <= (mode_q == MODE_SQRT)
                    ? CW'(RS) : CW'(RC);
          end
        end
        S_ROOT: begin
          rem_q  <= rem_d;
          root_q <= root_d;
          sq_q   <= sq_d;
          bsh_q  <= bsh_d;
          rcnt_q <= rcnt_q - CW'(1);
        end
        S_SUM: begin
          sum_q <= SW'(prod) + SW'(root_q);
        end
        S_DONE: begin
          y_q     <= sum_q[W-1:0];
          ovf_q   <= |sum_q[SW-1:W];
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign y     = y_q;
  assign ovf   = ovf_q;
  assign ready = ready_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_power_root_sum.sv
// Scoreboard bench for power_root_sum (W=16).
// Driver queues expectations, monitor checks.
module tb_power_root_sum;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] y;
  logic         ready;
  logic         busy;
  logic         ovf;

  typedef struct {
    logic [W-1:0] y;
    logic         ovf;
    int           acc;
    int           lat;
    bit           b2b;
  } exp_t;

  exp_t         q[$];
  exp_t         me;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           prev_rdy = -1000;
  logic [W-1:0] last_y = '0;
  logic         last_ovf = 1'b0;
  bit           held = 0;
  bit           first_held = 0;

  power_root_sum #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .y     (y),
    .ready (ready),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint iroot(longint v, bit m);
    longint r = 0;
    if (m) begin
      while ((r + 1) * (r + 1) <= v) r++;
    end else begin
      while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    end
    return r;
  endfunction

  task automatic check(string name, longint act,
                       longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  task automatic drive(bit s, logic [W-1:0] av,
                       logic [W-1:0] bv, bit m);
    exp_t   e;
    longint full;
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    mode  = m;
    if (s && !busy && !rst) begin
      full  = longint'(av) * longint'(av)
            + iroot(longint'(bv), m);
      e.y   = full[W-1:0];
      e.ovf = (full > 65535);
      e.acc = cyc + 1;
      e.lat = m ? 26 : 24;
      e.b2b = held && !first_held;
      first_held = 0;
      q.push_back(e);
    end
  endtask

  task automatic drive_noise();
    drive(0, W'($urandom), W'($urandom),
          1'($urandom));
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
      drive_noise();
    end
    check("done_timeout", done, 1);
  endtask

  task automatic run_op(logic [W-1:0] av,
                        logic [W-1:0] bv, bit m);
    drive(1, av, bv, m);
    wait_done();
  endtask

  // scoreboard monitor: pop on ready, otherwise outputs must hold
  always @(negedge clk) begin
    if (!rst) begin
      if (ready) begin
        if (q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          me = q.pop_front();
          check("y", y, me.y);
          check("ovf", ovf, me.ovf);
          check("latency", cyc - me.acc, me.lat);
          if (me.b2b)
            check("b2b_period", cyc - prev_rdy,
                  me.lat + 1);
          last_y   = me.y;
          last_ovf = me.ovf;
        end
        prev_rdy = cyc;
      end else begin
        check("y_hold", y, last_y);
        check("ovf_hold", ovf, last_ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_y", y, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    drive(0, '0, '0, 0);

    run_op(3, 27, 0);
    run_op(255, 65535, 0);
    run_op(0, 7, 0);
    run_op(0, 8, 0);
    run_op(10, 65535, 1);
    run_op(256, 0, 1);
    run_op(0, 0, 0);
    run_op(65535, 65535, 1);

    drive(1, 5, 100, 1);
    repeat (4) drive_noise();
    drive(1, 7, 200, 0);
    wait_done();

    drive(1, 9, 1000, 0);
    repeat (9) drive_noise();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_y", y, 0);
    check("abort_ready", ready, 0);
    check("abort_busy", busy, 0);
    check("abort_ovf", ovf, 0);
    q.delete();
    last_y   = '0;
    last_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op(2, 64, 0);
    check("post_rst_y", y, 8);

    held       = 1;
    first_held = 1;
    for (int k = 0; k < 110; k++) begin
      drive(1, W'($urandom), W'($urandom),
            1'($urandom));
    end
    held = 0;
    wait_done();

    for (int k = 0; k < 20; k++) begin
      run_op(($urandom_range(0, 3) == 0)
               ? W'($urandom)
               : W'($urandom_range(0, 255)),
             W'($urandom), 1'($urandom));
    end

    repeat (3) drive_noise();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
